// File: rtl/jt12_i2s_tx.sv
// Stereo I2S transmitter: one-entry sample buffer, self-generated BCLK/LRCK, 16-bit slots.
// Define JT12_I2S_LJ_EN for left-justified framing (LRCK high = left, aligned with the MSB).
module jt12_i2s_tx #(
    parameter int DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample,
    input  logic [13:0] left,
    input  logic [13:0] right,
    output logic        bclk,
    output logic        lrck,
    output logic        sdata,
    output logic        overrun,
    output logic        underrun
);
    localparam int DW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);

    logic [DW-1:0] r_div;
    logic          r_bclk;
    logic          r_lrck;
    logic          r_sdata;
    logic          r_overrun;
    logic          r_underrun;
    logic [4:0]    r_f;
    logic [13:0]   r_hold_l;
    logic [13:0]   r_hold_r;
    logic          r_hold_valid;
    logic [31:0]   r_shift;

    logic          w_wrap;
    logic          w_fall;
    logic [4:0]    w_f_new;
    logic          w_load;
    logic          w_lrck_next;
    logic [31:0]   w_frame;

    assign w_wrap  = (r_div == DIV_MAX);
    assign w_fall  = w_wrap & r_bclk;
    assign w_f_new = r_f + 5'd1;
    assign w_load  = w_fall & (w_f_new == 5'd0);
    assign w_frame = {r_hold_l, 2'b00, r_hold_r, 2'b00};

`ifdef JT12_I2S_LJ_EN
    assign w_lrck_next = (w_f_new <= 5'd15);
`else
    // Standard I2S: word select changes one bit clock ahead of the MSB.
    assign w_lrck_next = (w_f_new >= 5'd15) && (w_f_new <= 5'd30);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div        <= '0;
            r_bclk       <= 1'b0;
            r_lrck       <= 1'b0;
            r_sdata      <= 1'b0;
            r_overrun    <= 1'b0;
            r_underrun   <= 1'b0;
            r_f          <= 5'd31;
            r_hold_l     <= '0;
            r_hold_r     <= '0;
            r_hold_valid <= 1'b0;
            r_shift      <= '0;
        end else begin
            r_overrun  <= 1'b0;
            r_underrun <= 1'b0;
            r_div      <= w_wrap ? '0 : r_div + 1'b1;
            if (w_wrap) begin
                r_bclk <= ~r_bclk;
            end

            if (w_fall) begin
                r_f    <= w_f_new;
                r_lrck <= w_lrck_next;
                if (w_load) begin
                    // Hold regs are never cleared, so an empty buffer replays the last pair.
                    r_shift    <= w_frame;
                    r_sdata    <= w_frame[31];
                    r_underrun <= ~r_hold_valid & ~sample;
                end else begin
                    r_sdata <= r_shift[~w_f_new];
                end
            end

            // A coincident strobe lands in hold after the load consumed the old pair.
            if (sample) begin
                r_hold_l     <= left;
                r_hold_r     <= right;
                r_hold_valid <= 1'b1;
                r_overrun    <= r_hold_valid & ~w_load;
            end else if (w_load) begin
                r_hold_valid <= 1'b0;
            end
        end
    end

    assign bclk     = r_bclk;
    assign lrck     = r_lrck;
    assign sdata    = r_sdata;
    assign overrun  = r_overrun;
    assign underrun = r_underrun;
endmodule

// File: tb/tb_jt12_i2s_tx.sv
// Bench for jt12_i2s_tx: per-cycle reference model plus directed frame vectors and random strobes.
module tb_jt12_i2s_tx;
    localparam int DIV = 2;
    localparam int HP  = 2 * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample = 1'b0;
    logic [13:0] left = '0;
    logic [13:0] right = '0;
    logic        bclk, lrck, sdata, overrun, underrun;

    jt12_i2s_tx #(.DIV(DIV)) dut (
        .clk(clk), .rst(rst), .sample(sample), .left(left), .right(right),
        .bclk(bclk), .lrck(lrck), .sdata(sdata), .overrun(overrun), .underrun(underrun)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: time is counted in core clock edges since reset release.
    int          cyc;
    int          cur_slot;
    bit          last_fall;
    logic [13:0] m_l, m_r;
    bit          m_valid;
    logic [31:0] m_frame;
    logic        e_bclk, e_lrck, e_sdata, e_over, e_under;
    logic [31:0] cap_word;
    int          over_seen, under_seen;

    typedef struct {
        logic [13:0] l;
        logic [13:0] r;
        logic [15:0] el;
        logic [15:0] er;
    } vec_t;
    vec_t tbl[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d slot=%0d: got %h expected %h", name, cyc, cur_slot, act, exp);
        end
    endtask

    task automatic model_reset();
        cyc = 0; cur_slot = 31; last_fall = 0;
        m_l = '0; m_r = '0; m_valid = 0; m_frame = '0;
        e_bclk = 0; e_lrck = 0; e_sdata = 0; e_over = 0; e_under = 0;
    endtask

    task automatic model_edge(input bit s, input logic [13:0] l, input logic [13:0] r);
        e_over = 0; e_under = 0; last_fall = 0;
        e_bclk = ((cyc / DIV) % 2) == 1;
        if (cyc % HP == 0) begin
            last_fall = 1;
            cur_slot = (cyc / HP - 1) % 32;
`ifdef JT12_I2S_LJ_EN
            e_lrck = (cur_slot <= 15);
`else
            e_lrck = (cur_slot >= 15) && (cur_slot <= 30);
`endif
            if (cur_slot == 0) begin
                m_frame = {m_l, 2'b00, m_r, 2'b00};
                e_under = !m_valid && !s;
                m_valid = 0;
            end
            e_sdata = m_frame[31 - cur_slot];
        end
        if (s) begin
            e_over = m_valid;
            m_l = l; m_r = r; m_valid = 1;
        end
    endtask

    task automatic step(input bit s, input logic [13:0] l, input logic [13:0] r);
        sample = s; left = l; right = r;
        @(posedge clk);
        cyc++;
        model_edge(s, l, r);
        @(negedge clk);
        sample = 0;
        check("bclk", 32'(bclk), 32'(e_bclk));
        check("lrck", 32'(lrck), 32'(e_lrck));
        check("sdata", 32'(sdata), 32'(e_sdata));
        check("overrun", 32'(overrun), 32'(e_over));
        check("underrun", 32'(underrun), 32'(e_under));
        if (overrun) over_seen++;
        if (underrun) under_seen++;
        if (last_fall) cap_word[31 - cur_slot] = sdata;
    endtask

    task automatic run_until_slot(input int target);
        for (int i = 0; i < 400; i++) begin
            step(0, '0, '0);
            if (last_fall && cur_slot == target) return;
        end
        errors++;
        $display("FAIL slot_timeout: slot %0d not reached, current %0d", target, cur_slot);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_bclk"}, 32'(bclk), 32'd0);
        check({tag, "_lrck"}, 32'(lrck), 32'd0);
        check({tag, "_sdata"}, 32'(sdata), 32'd0);
        check({tag, "_overrun"}, 32'(overrun), 32'd0);
        check({tag, "_underrun"}, 32'(underrun), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{14'h1FFF, 14'h2000, 16'h7FFC, 16'h8000};
        tbl[1] = '{14'h0000, 14'h3FFF, 16'h0000, 16'hFFFC};
        tbl[2] = '{14'h1555, 14'h0AAA, 16'h5554, 16'h2AA8};
        tbl[3] = '{14'h2001, 14'h1234, 16'h8004, 16'h48D0};
        model_reset();
        cap_word = '0; over_seen = 0; under_seen = 0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;

        // Idle: first frame replays the zero pair with an underrun.
        run_until_slot(0);
        check("idle_underrun_count", 32'(under_seen), 32'd1);
        run_until_slot(31);
        check("idle_frame", cap_word, 32'h0);

        // Directed frames: strobe in slot 31, frame follows at the next slot 0.
        for (int i = 0; i < 4; i++) begin
            under_seen = 0;
            step(1, tbl[i].l, tbl[i].r);
            run_until_slot(31);
            check("vec_frame", cap_word, {tbl[i].el, tbl[i].er});
            check("vec_no_underrun", 32'(under_seen), 32'd0);
        end

        // Two strobes between frames: second overwrites, one overrun.
        over_seen = 0;
        step(1, 14'h0001, 14'h0000);
        step(1, 14'h0002, 14'h0000);
        run_until_slot(31);
        check("overrun_count", 32'(over_seen), 32'd1);
        check("overrun_left_word", 32'(cap_word[31:16]), 32'h0008);

        // Strobe coincident with the slot-0 load.
        over_seen = 0; under_seen = 0;
        step(1, 14'h0100, 14'h0100);
        repeat (HP - 2) step(0, '0, '0);
        step(1, 14'h0200, 14'h0200);
        check("coinc_is_load", 32'(last_fall && cur_slot == 0), 32'd1);
        check("coinc_overrun", 32'(overrun), 32'd0);
        check("coinc_underrun", 32'(underrun), 32'd0);
        run_until_slot(31);
        check("coinc_old_frame", cap_word, 32'h0400_0400);
        run_until_slot(31);
        check("coinc_new_frame", cap_word, 32'h0800_0800);
        check("coinc_pulses", 32'(over_seen + under_seen), 32'd0);

        // Random strobes and data against the model.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 39) == 0, 14'($urandom_range(0, 16383)),
                 14'($urandom_range(0, 16383)));
        end

        // Reset mid-frame at slot 20.
        run_until_slot(20);
        rst = 1'b1;
        #1;
        check_outputs_zero("midrst");
        repeat (2) @(negedge clk);
        check_outputs_zero("midrst_hold");
        rst = 1'b0;
        model_reset();
        under_seen = 0;
        run_until_slot(0);
        check("midrst_underrun", 32'(under_seen), 32'd1);
        run_until_slot(31);
        check("midrst_frame", cap_word, 32'h0);
        step(1, 14'h0ABC, 14'h1DEF);
        run_until_slot(31);
        check("midrst_restart_frame", cap_word, {16'h2AF0, 16'h77BC});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/jt12_i2s_tx.md
Name: jt12_i2s_tx

Overview:
Stereo serial audio transmitter downstream of the JT12 channel accumulator. Captures each 14-bit signed left/right sample pair when the accumulator publishes it, and holds it in a one-entry buffer. Serializes the pair as 16-bit I2S frames on self-generated BCLK/LRCK for an external DAC. Runs in the FM core clock domain; no CDC inside.

Parameters:
DIV, 4, core clk cycles per BCLK half-period (>=2); BCLK = clk/(2*DIV)

Ports:
clk  in  1  core clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
sample  in  1  one-cycle strobe: left/right valid this cycle (driven from the accumulator's output-update event)
left  in  14  signed left sample
right  in  14  signed right sample
bclk  out  1  serial bit clock
lrck  out  1  word select
sdata  out  1  serial data, MSB first
overrun  out  1  one-cycle pulse: an unconsumed buffered sample was overwritten
underrun  out  1  one-cycle pulse: frame start with no new sample; previous pair repeated

Behaviour:
- Reset (async, active-high) values: bclk=0, lrck=0, sdata=0, overrun=0, underrun=0; divider=0; slot counter f=31; hold regs=0; hold_valid=0; shift reg=0.
- Divider counts 0..DIV-1 and wraps. On wrap, bclk toggles. A wrap with bclk=1 (toggle to 0) is a falling event.
- Each falling event: f <= f+1 mod 32, entering slot f_new. All outputs below are registered on that same clk edge.
- Entering slot 0: 32-bit shift reg loads {hold_l,hold_r}; hold_valid<=0. If hold_valid was 0, the previously loaded pair is reloaded and underrun pulses for one clk.
- Word formation: 16-bit word = {sample[13:0],2'b00}, i.e. 14-bit value left-shifted by 2. Left word occupies slots 0..15, right word slots 16..31, MSB first.
- sdata in slot f = shift reg bit (31-f). For slot 0 this is the freshly loaded MSB.
- I2S alignment: lrck updates on each falling event to 1 when f_new in 15..30, else 0. lrck therefore leads the MSB by one BCLK; lrck=0 marks left.
- Capture: sample=1 writes left/right into hold regs and sets hold_valid.
- If sample=1 while hold_valid=1 and no slot-0 load happens that cycle: new data overwrites and overrun pulses for one clk.
- Simultaneous sample and slot-0 load: the shift reg takes the OLD hold contents; the new pair is written to hold; hold_valid stays 1; no overrun and no underrun.
- sample strobes in consecutive cycles are legal; each one is evaluated independently by the rules above.
- rst asserted mid-frame: immediate return to reset values. The first falling event after release enters slot 0 and loads zeros with underrun=1, unless a sample has been captured by then.
- Latency: a sample captured before a slot-0 entry appears at the sdata MSB at that entry.

Optional Feature:
JT12_I2S_LJ_EN
- Defined: left-justified format. lrck = 1 when f_new in 0..15 (high = left), changing together with the MSB rather than one slot early. Data timing is unchanged.
- Undefined: standard I2S as specified above.

Test Plan:
- Reset then idle, DIV=2: bclk period 4 clk, 50% duty; first falling event enters slot 0 with underrun=1; sdata stays 0 for 32 slots; lrck=1 in slots 15..30.
- sample with left=14'h1FFF, right=14'h2000 before slot 0 -> left word 16'h7FFC, right word 16'h8000 on sdata MSB first; lrck falls one BCLK before the left MSB.
- Two samples between frames (left 14'h0001, then 14'h0002) -> overrun pulses once; frame carries 16'h0008.
- sample coincident with slot-0 load: old pair 14'h0100 is sent, new pair 14'h0200 is sent in the next frame; no overrun or underrun pulse.
- Assert rst at slot 20 -> all outputs 0 immediately; after release, serialization restarts from slot 0.
- With JT12_I2S_LJ_EN defined -> lrck=1 in slots 0..15, transitions coincide with MSB slots; same sdata as I2S case.
